// File: rtl/clock_ratio_monitor.sv
// Measures clk2/clk4 periods in CLK_exit cycles and checks period4 == 2*period2 within TOL, asserting locked after LOCK_N good checks.
// Latency: results update 2 edges after an input edge is first sampled; no backpressure, outputs are status only.
module clock_ratio_monitor #(
  parameter int CNT_W  = 12,
  parameter int LOCK_N = 4,
  parameter int TOL    = 1
) (
  input  logic             CLK_exit,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clk2,
  input  logic             clk4,
  output logic [CNT_W-1:0] period2,
  output logic [CNT_W-1:0] period4,
  output logic             meas_valid,
  output logic             ratio_ok,
  output logic             locked,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOCKED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W+1:0] TOL_V   = (CNT_W+2)'(TOL);
  localparam logic [3:0]       LOCK_V  = 4'(LOCK_N);

  state_t           state;
  logic [2:0]       sh2, sh4;
  logic [CNT_W-1:0] cnt2, cnt4;
  logic             seen2, seen4, valid2, valid4;
  logic [3:0]       good_cnt;

  logic             rise2, rise4, timeout, cmp, good;
  logic [CNT_W+1:0] p4_ext, two_p2, diff;
  logic [3:0]       good_inc;

  assign rise2    = sh2[1] & ~sh2[2];
  assign rise4    = sh4[1] & ~sh4[2];
  assign timeout  = (cnt2 == CNT_MAX) | (cnt4 == CNT_MAX);
  // valid2 is the registered flag so the comparison always pairs with a period2 that is already stored
  assign cmp      = rise4 & seen4 & valid2;
  assign p4_ext   = {2'b00, cnt4 + 1'b1};
  assign two_p2   = {1'b0, period2, 1'b0};
  assign diff     = (p4_ext >= two_p2) ? (p4_ext - two_p2) : (two_p2 - p4_ext);
  assign good     = (diff <= TOL_V);
  assign good_inc = good_cnt + 4'd1;

  always_ff @(posedge CLK_exit) begin
    if (!rst_n) begin
      sh2 <= '0;
      sh4 <= '0;
    end else begin
      sh2 <= {sh2[1:0], clk2};
      sh4 <= {sh4[1:0], clk4};
    end
  end

  always_ff @(posedge CLK_exit) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt2       <= '0;
      cnt4       <= '0;
      seen2      <= 1'b0;
      seen4      <= 1'b0;
      valid2     <= 1'b0;
      valid4     <= 1'b0;
      good_cnt   <= '0;
      period2    <= '0;
      period4    <= '0;
      meas_valid <= 1'b0;
      ratio_ok   <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      err        <= 1'b0;
      if (!en) begin
        state    <= IDLE;
        cnt2     <= '0;
        cnt4     <= '0;
        seen2    <= 1'b0;
        seen4    <= 1'b0;
        valid2   <= 1'b0;
        valid4   <= 1'b0;
        good_cnt <= '0;
        period2  <= '0;
        period4  <= '0;
        ratio_ok <= 1'b0;
        locked   <= 1'b0;
      end else if (state == IDLE) begin
        state <= ACQ;
      end else if (timeout) begin
        err      <= 1'b1;
        state    <= ACQ;
        cnt2     <= '0;
        cnt4     <= '0;
        seen2    <= 1'b0;
        seen4    <= 1'b0;
        valid2   <= 1'b0;
        valid4   <= 1'b0;
        good_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        cnt2 <= rise2 ? '0 : cnt2 + 1'b1;
        cnt4 <= rise4 ? '0 : cnt4 + 1'b1;
        if (rise2) begin
          seen2 <= 1'b1;
          if (seen2) begin
            period2 <= cnt2 + 1'b1;
            valid2  <= 1'b1;
          end
        end
        if (rise4) begin
          seen4 <= 1'b1;
          if (seen4) begin
            period4 <= cnt4 + 1'b1;
            valid4  <= 1'b1;
          end
        end
        if (cmp) begin
          meas_valid <= 1'b1;
          ratio_ok   <= good;
          if (!good) err <= 1'b1;
          case (state)
            ACQ: begin
              state    <= TRACK;
              good_cnt <= good ? 4'd1 : 4'd0;
            end
            TRACK: begin
              if (good) begin
                good_cnt <= good_inc;
                if (good_inc == LOCK_V) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                good_cnt <= '0;
              end
            end
            LOCKED: begin
              if (!good) begin
                state    <= TRACK;
                locked   <= 1'b0;
                good_cnt <= '0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Directed bench for clock_ratio_monitor: table of steady clock patterns plus hand sequences for lock loss, disable and period changes.
module tb_clock_ratio_monitor;

  logic        CLK_exit, rst_n, en, clk2, clk4;
  logic [11:0] period2, period4;
  logic        meas_valid, ratio_ok, locked, err;

  clock_ratio_monitor #(.CNT_W(12), .LOCK_N(4), .TOL(1)) dut (
    .CLK_exit(CLK_exit), .rst_n(rst_n), .en(en), .clk2(clk2), .clk4(clk4),
    .period2(period2), .period4(period4), .meas_valid(meas_valid),
    .ratio_ok(ratio_ok), .locked(locked), .err(err)
  );

  typedef struct {
    int p2, p4a, p4b, n;
    int e_p2, e_p4, e_ok, e_lk, e_errs;
    bit chk_err;
  } vec_t;

  vec_t vecs[6];
  int   checks, errors, meas_cnt, err_cnt, last_wait;
  bit   gen_on, g_hold;
  int   g_p2, g_p4a, g_p4b;
  int   c2, c4, cur2, cur4;
  bit   alt, hold_act;

  initial begin
    CLK_exit = 1'b0;
    forever #5 CLK_exit = ~CLK_exit;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // clk2/clk4 pattern generator; clk4 alternates between g_p4a and g_p4b periods
  initial begin
    clk2 = 1'b0;
    clk4 = 1'b0;
    forever begin
      @(posedge CLK_exit);
      #1;
      if (!gen_on) begin
        c2 = 0; c4 = 0; cur2 = g_p2; cur4 = g_p4a; alt = 0; hold_act = 0;
        clk2 = 1'b0; clk4 = 1'b0;
      end else begin
        if (c2 == 0 && c4 == 0) cur2 = g_p2;
        if (g_hold) hold_act = 1;
        else if (c4 == 0) hold_act = 0;
        clk2 = (c2 < cur2 / 2);
        clk4 = hold_act ? 1'b0 : (c4 < cur4 / 2);
        c2++;
        if (c2 >= cur2) c2 = 0;
        c4++;
        if (c4 >= cur4) begin
          c4 = 0;
          alt = !alt;
          cur4 = alt ? g_p4b : g_p4a;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK_exit);
    if (meas_valid) meas_cnt++;
    if (err) err_cnt++;
  endtask

  task automatic wait_meas(input int budget, input string name);
    int  k;
    bit  got;
    k = 0;
    got = 0;
    while (!got && k < budget) begin
      tick();
      k++;
      got = meas_valid;
    end
    last_wait = k;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: no meas_valid within %0d cycles", name, budget);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    en     = 1'b0;
    gen_on = 1'b0;
    g_hold = 1'b0;
    repeat (3) tick();
    chk("reset_zero", int'({period2, period4, meas_valid, ratio_ok, locked, err}), 0);
    rst_n = 1'b1;
  endtask

  task automatic start(input int p2, input int p4a, input int p4b);
    g_p2 = p2; g_p4a = p4a; g_p4b = p4b;
    tick();
    en = 1'b1;
    gen_on = 1'b1;
  endtask

  initial begin
    int first, st, e0, m0, k;
    bit got;
    checks = 0; errors = 0; meas_cnt = 0; err_cnt = 0; last_wait = 0;
    rst_n = 1'b0; en = 1'b0; gen_on = 1'b0; g_hold = 1'b0;
    g_p2 = 8; g_p4a = 16; g_p4b = 16;

    //            p2 p4a p4b n  e_p2 e_p4 ok lk errs chk_err
    vecs[0] = '{ 8, 16, 16, 4,  8,  16,  1, 1, 0, 1'b1};
    vecs[1] = '{ 8, 15, 17, 4,  8,  17,  1, 1, 0, 1'b1};
    vecs[2] = '{ 6, 12, 12, 4,  6,  12,  1, 1, 0, 1'b1};
    vecs[3] = '{ 8, 17, 17, 4,  8,  17,  1, 1, 0, 1'b1};
    vecs[4] = '{ 8, 14, 14, 3,  8,  14,  0, 0, 0, 1'b0};
    vecs[5] = '{10, 20, 20, 3, 10,  20,  1, 0, 0, 1'b1};

    // static inputs: first timeout after 4096 ACQ edges
    do_reset();
    en = 1'b1;
    first = 0; st = -1; e0 = err_cnt; m0 = meas_cnt;
    for (int i = 1; i <= 4200; i++) begin
      tick();
      if (err && first == 0) begin
        first = i;
        st = int'(dut.state);
      end
    end
    chk("timeout_tick", first, 4097);
    chk("timeout_state", st, 1);
    chk("timeout_err_count", err_cnt - e0, 1);
    chk("static_no_meas", meas_cnt - m0, 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      start(vecs[i].p2, vecs[i].p4a, vecs[i].p4b);
      e0 = err_cnt;
      for (int m = 0; m < vecs[i].n; m++) wait_meas(400, $sformatf("row%0d_meas", i));
      chk($sformatf("row%0d_period2", i), int'(period2), vecs[i].e_p2);
      chk($sformatf("row%0d_period4", i), int'(period4), vecs[i].e_p4);
      chk($sformatf("row%0d_ratio_ok", i), int'(ratio_ok), vecs[i].e_ok);
      chk($sformatf("row%0d_locked", i), int'(locked), vecs[i].e_lk);
      if (vecs[i].chk_err) chk($sformatf("row%0d_err_pulses", i), err_cnt - e0, vecs[i].e_errs);
    end

    // nominal lock, then one-cycle disable and re-arm
    do_reset();
    start(8, 16, 16);
    e0 = err_cnt;
    for (int m = 0; m < 3; m++) wait_meas(400, "nom_meas");
    chk("nom_not_yet_locked", int'(locked), 0);
    wait_meas(400, "nom_meas4");
    chk("nom_locked", int'(locked), 1);
    chk("nom_no_err", err_cnt - e0, 0);
    en = 1'b0;
    tick();
    chk("dis_outputs", int'({period2, period4, meas_valid, ratio_ok, locked, err}), 0);
    chk("dis_state", int'(dut.state), 0);
    en = 1'b1;
    wait_meas(400, "reen_meas");
    chk("reen_delay", int'(last_wait >= 16), 1);
    chk("reen_period2", int'(period2), 8);
    chk("reen_period4", int'(period4), 16);
    for (int m = 0; m < 3; m++) wait_meas(400, "reen_lock_meas");
    chk("reen_locked", int'(locked), 1);

    // loss of lock: clk4 stuck low
    g_hold = 1'b1;
    k = 0; got = 0;
    while (!got && k < 5000) begin
      tick();
      k++;
      got = err;
    end
    chk("lol_err_seen", int'(got), 1);
    chk("lol_locked", int'(locked), 0);
    chk("lol_state", int'(dut.state), 1);
    chk("lol_wait_long", int'(k >= 4000), 1);
    g_hold = 1'b0;
    e0 = err_cnt;
    for (int m = 0; m < 3; m++) wait_meas(400, "relock_meas");
    chk("relock_early", int'(locked), 0);
    wait_meas(400, "relock_meas4");
    chk("relock_locked", int'(locked), 1);
    chk("relock_ok", int'(ratio_ok), 1);
    chk("relock_no_err", err_cnt - e0, 0);

    // clk2 period 8 -> 10 at a shared edge
    g_p2 = 10;
    wait_meas(400, "sim_meas1");
    chk("sim_period2_old", int'(period2), 8);
    chk("sim_period4", int'(period4), 16);
    chk("sim_ok_first", int'(ratio_ok), 1);
    wait_meas(400, "sim_meas2");
    chk("sim_period2_new", int'(period2), 10);
    chk("sim_ok_second", int'(ratio_ok), 0);
    chk("sim_err", int'(err), 1);
    chk("sim_locked", int'(locked), 0);

    // tolerance edge: 15/17 locks, then 18 breaks it
    do_reset();
    start(8, 15, 17);
    for (int m = 0; m < 4; m++) wait_meas(400, "tol_meas");
    chk("tol_locked", int'(locked), 1);
    g_p4a = 18;
    g_p4b = 18;
    wait_meas(400, "tol_meas5");
    chk("tol_period4_15", int'(period4), 15);
    chk("tol_ok_15", int'(ratio_ok), 1);
    chk("tol_locked_15", int'(locked), 1);
    wait_meas(400, "tol_meas6");
    chk("tol_period4_18", int'(period4), 18);
    chk("tol_ok_18", int'(ratio_ok), 0);
    chk("tol_err_18", int'(err), 1);
    chk("tol_locked_18", int'(locked), 0);
    tick();
    chk("err_single_cycle", int'(err), 0);
    chk("meas_single_cycle", int'(meas_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
